// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch stage. Owns the PC, issues one instruction-memory request
// at a time and presents the fetched word to the IF/ID register. A bubble is
// all-zero inst/pc/pc4 with IF_valid low. flush redirects fetch to redirect_pc
// and overrides stall. A response that was already in flight when the flush
// arrived is marked for discard and is never delivered.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_pc4,
    output logic        IF_valid
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_r;
    logic [31:0] pc_next;
    logic [31:0] inst_buf;
    logic [31:0] inst_buf_next;
    logic        discard;
    logic        discard_next;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;

    assign pc_plus4         = pc_r + 32'd4;
    assign redirect_aligned = redirect_pc & WORD_MASK;

    // State and datapath registers; rst_n is an active-high asynchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= FETCH;
            pc_r     <= RESET_PC;
            inst_buf <= '0;
            discard  <= 1'b0;
        end else begin
            state    <= state_next;
            pc_r     <= pc_next;
            inst_buf <= inst_buf_next;
            discard  <= discard_next;
        end
    end

    // Next-state logic: a flush redirects the PC and forgets any in-flight fetch.
    always_comb begin
        state_next    = state;
        pc_next       = pc_r;
        inst_buf_next = inst_buf;
        discard_next  = discard;
        if (flush) begin
            pc_next    = redirect_aligned;
            state_next = FETCH;
            case (state)
                WAIT: begin
                    // A response landing in the flush cycle is simply dropped;
                    // otherwise the one still in flight must be thrown away later.
                    discard_next = ~imem_rvalid;
                end
                FETCH: begin
                    if (imem_rvalid) begin
                        discard_next = 1'b0;
                    end
                end
                HOLD: begin
                    inst_buf_next = '0;
                end
                default: begin
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    // While a stale response is outstanding no new request may
                    // go out, so wait here until it drains.
                    if (discard) begin
                        if (imem_rvalid) begin
                            discard_next = 1'b0;
                        end
                    end else begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard_next = 1'b0;
                            state_next   = FETCH;
                        end else begin
                            inst_buf_next = imem_rdata;
                            state_next    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // IF/ID takes the instruction at this edge; the sequential
                    // request has already been issued in this cycle.
                    if (!stall) begin
                        pc_next    = pc_plus4;
                        state_next = WAIT;
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    // Output decode: memory request strobe and the IF/ID-facing instruction view.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        IF_inst   = '0;
        IF_pc     = '0;
        IF_pc4    = '0;
        IF_valid  = 1'b0;
        if (!rst_n && !flush) begin
            case (state)
                FETCH: begin
                    if (!discard) begin
                        imem_req  = 1'b1;
                        imem_addr = pc_r & WORD_MASK;
                    end
                end
                HOLD: begin
                    IF_valid = 1'b1;
                    IF_inst  = inst_buf;
                    IF_pc    = pc_r;
                    IF_pc4   = pc_plus4;
                    if (!stall) begin
                        imem_req  = 1'b1;
                        imem_addr = pc_plus4 & WORD_MASK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit
// Directed scenarios for the fetch stage followed by a randomized run checked
// against an instruction-stream model: every delivered instruction must be the
// next one in program order (restarting at each redirect), memory returns
// addr ^ KEY, and at most one request may be in flight.
module tb_if_fetch_unit;

    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    localparam logic [31:0] RST_PC = 32'h0000_0200;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;
    logic [31:0] IF_pc4;
    logic        IF_valid;

    int checks = 0;
    int errors = 0;

    // Memory model state
    logic        mem_pend;
    int          mem_left;
    logic [31:0] mem_raddr;
    int          mem_lat    = 1;
    bit          rand_lat   = 0;
    logic        inj_rvalid = 1'b0;
    logic [31:0] inj_data   = '0;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst),
        .stall      (stall),
        .flush      (flush),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .IF_inst    (IF_inst),
        .IF_pc      (IF_pc),
        .IF_pc4     (IF_pc4),
        .IF_valid   (IF_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: answers each accepted request after mem_lat cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_pend  <= 1'b0;
            mem_left  <= 0;
            mem_raddr <= '0;
        end else begin
            if (mem_pend && mem_left == 0) begin
                mem_pend <= 1'b0;
            end else if (mem_pend) begin
                mem_left <= mem_left - 1;
            end
            if (imem_req) begin
                mem_pend  <= 1'b1;
                mem_left  <= rand_lat ? int'($urandom_range(2, 0)) : mem_lat - 1;
                mem_raddr <= imem_addr;
            end
        end
    end

    assign imem_rvalid = (mem_pend && mem_left == 0) || inj_rvalid;
    assign imem_rdata  = (mem_pend && mem_left == 0) ? (mem_raddr ^ KEY) : inj_data;

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (IF_valid !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (IF_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_valid timeout IF_valid=%b want 1", IF_valid);
        end
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_pc = '0;
        #3;
        checks++;
        if ({imem_req, imem_addr, IF_valid, IF_inst, IF_pc, IF_pc4} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs req=%b addr=%h valid=%b inst=%h pc=%h pc4=%h want all 0",
                     imem_req, imem_addr, IF_valid, IF_inst, IF_pc, IF_pc4);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("[TB] FAIL reset_first_req req=%b addr=%h want 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_sequential;
        bit exp_req;
        bit exp_valid;
        logic [31:0] exp_pc;
        wait_valid(10);
        flush       = 1'b1;
        redirect_pc = 32'h0;
        #1;
        checks++;
        if (IF_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL seq_flush_bubble valid=%b req=%b want 0 0", IF_valid, imem_req);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            flush = 1'b0;
            #1;
            exp_req   = (k % 2 == 0);
            exp_valid = (k >= 2) && (k % 2 == 0);
            checks++;
            if (imem_req !== exp_req || IF_valid !== exp_valid) begin
                errors++;
                $display("[TB] FAIL seq_strobes k=%0d req=%b valid=%b want %b %b",
                         k, imem_req, IF_valid, exp_req, exp_valid);
            end
            if (exp_req) begin
                checks++;
                if (imem_addr !== 32'(4 * (k / 2))) begin
                    errors++;
                    $display("[TB] FAIL seq_addr k=%0d got %h want %h", k, imem_addr, 32'(4 * (k / 2)));
                end
            end
            if (exp_valid) begin
                exp_pc = 32'(4 * (k / 2 - 1));
                checks++;
                if (IF_pc !== exp_pc || IF_pc4 !== exp_pc + 32'd4 || IF_inst !== (exp_pc ^ KEY)) begin
                    errors++;
                    $display("[TB] FAIL seq_data k=%0d pc=%h pc4=%h inst=%h want %h %h %h",
                             k, IF_pc, IF_pc4, IF_inst, exp_pc, exp_pc + 32'd4, exp_pc ^ KEY);
                end
            end else begin
                checks++;
                if ({IF_inst, IF_pc, IF_pc4} !== '0) begin
                    errors++;
                    $display("[TB] FAIL seq_bubble k=%0d inst=%h pc=%h pc4=%h want 0",
                             k, IF_inst, IF_pc, IF_pc4);
                end
            end
        end
    endtask

    task automatic test_stall;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            stall      = 1'b1;
            inj_rvalid = (s == 1);
            inj_data   = 32'hDEAD_BEEF;
            #1;
            checks++;
            if (IF_valid !== 1'b1 || IF_pc !== 32'h8 || IF_pc4 !== 32'hC ||
                IF_inst !== (32'h8 ^ KEY) || imem_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold s=%0d valid=%b pc=%h pc4=%h inst=%h req=%b want 1 8 c %h 0",
                         s, IF_valid, IF_pc, IF_pc4, IF_inst, imem_req, 32'h8 ^ KEY);
            end
        end
        @(negedge clk);
        stall      = 1'b0;
        inj_rvalid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC || IF_pc !== 32'h8 || IF_inst !== (32'h8 ^ KEY)) begin
            errors++;
            $display("[TB] FAIL stall_release req=%b addr=%h pc=%h inst=%h want 1 c 8 %h",
                     imem_req, imem_addr, IF_pc, IF_inst, 32'h8 ^ KEY);
        end
    endtask

    task automatic test_flush_hold;
        wait_valid(10);
        flush       = 1'b1;
        redirect_pc = 32'h100;
        #1;
        checks++;
        if ({IF_valid, IF_inst, IF_pc, IF_pc4, imem_req} !== '0) begin
            errors++;
            $display("[TB] FAIL flush_hold_bubble valid=%b inst=%h pc=%h pc4=%h req=%b want 0",
                     IF_valid, IF_inst, IF_pc, IF_pc4, imem_req);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || IF_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_hold_req req=%b addr=%h valid=%b want 1 100 0", imem_req, imem_addr, IF_valid);
        end
        wait_valid(10);
        checks++;
        if (IF_pc !== 32'h100 || IF_pc4 !== 32'h104 || IF_inst !== (32'h100 ^ KEY)) begin
            errors++;
            $display("[TB] FAIL flush_hold_data pc=%h pc4=%h inst=%h want 100 104 %h",
                     IF_pc, IF_pc4, IF_inst, 32'h100 ^ KEY);
        end
    endtask

    task automatic test_flush_wait;
        bit          saw_stale;
        bit          got_req;
        bit          early;
        logic [31:0] first_addr;
        int          n;
        saw_stale  = 0;
        got_req    = 0;
        early      = 0;
        first_addr = '0;
        mem_lat    = 3;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
            errors++;
            $display("[TB] FAIL flush_wait_seq_req req=%b addr=%h want 1 104", imem_req, imem_addr);
        end
        @(negedge clk);
        flush       = 1'b1;
        redirect_pc = 32'h43;
        #1;
        checks++;
        if (IF_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_wait_bubble valid=%b req=%b want 0 0", IF_valid, imem_req);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n = 0;
        while (IF_valid !== 1'b1 && n < 20) begin
            if (imem_rvalid && imem_rdata == (32'h104 ^ KEY)) saw_stale = 1;
            if (imem_req && !got_req) begin
                got_req    = 1;
                first_addr = imem_addr;
                if (!saw_stale) early = 1;
            end
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!saw_stale || early || !got_req) begin
            errors++;
            $display("[TB] FAIL flush_wait_order stale_seen=%b early_req=%b req_seen=%b want 1 0 1",
                     saw_stale, early, got_req);
        end
        checks++;
        if (first_addr !== 32'h40) begin
            errors++;
            $display("[TB] FAIL flush_wait_addr got %h want 40", first_addr);
        end
        checks++;
        if (IF_valid !== 1'b1 || IF_pc !== 32'h40 || IF_inst !== (32'h40 ^ KEY)) begin
            errors++;
            $display("[TB] FAIL flush_wait_data valid=%b pc=%h inst=%h want 1 40 %h",
                     IF_valid, IF_pc, IF_inst, 32'h40 ^ KEY);
        end
    endtask

    task automatic test_stall_flush;
        mem_lat     = 1;
        stall       = 1'b1;
        flush       = 1'b1;
        redirect_pc = 32'h80;
        #1;
        checks++;
        if ({IF_valid, IF_pc, imem_req} !== '0) begin
            errors++;
            $display("[TB] FAIL stall_flush_bubble valid=%b pc=%h req=%b want 0", IF_valid, IF_pc, imem_req);
        end
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            errors++;
            $display("[TB] FAIL stall_flush_req req=%b addr=%h want 1 80", imem_req, imem_addr);
        end
        wait_valid(10);
        checks++;
        if (IF_pc !== 32'h80 || IF_inst !== (32'h80 ^ KEY)) begin
            errors++;
            $display("[TB] FAIL stall_flush_data pc=%h inst=%h want 80 %h", IF_pc, IF_inst, 32'h80 ^ KEY);
        end
    endtask

    task automatic test_wrap;
        flush       = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("[TB] FAIL wrap_req req=%b addr=%h want 1 fffffffc", imem_req, imem_addr);
        end
        wait_valid(10);
        mem_lat = 3;
        checks++;
        if (IF_pc !== 32'hFFFF_FFFC || IF_pc4 !== 32'h0 || IF_inst !== (32'hFFFF_FFFC ^ KEY)) begin
            errors++;
            $display("[TB] FAIL wrap_data pc=%h pc4=%h inst=%h want fffffffc 0 %h",
                     IF_pc, IF_pc4, IF_inst, 32'hFFFF_FFFC ^ KEY);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_next_req req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        flush       = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_discard_hold req=%b want 0", imem_req);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr, IF_valid, IF_inst, IF_pc, IF_pc4} !== '0) begin
            errors++;
            $display("[TB] FAIL areset_wait_outputs req=%b addr=%h valid=%b want 0", imem_req, imem_addr, IF_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("[TB] FAIL areset_first_req req=%b addr=%h want 1 %h", imem_req, imem_addr, RST_PC);
        end
        wait_valid(10);
        stall = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({IF_valid, IF_inst, IF_pc, IF_pc4} !== '0) begin
            errors++;
            $display("[TB] FAIL areset_hold_outputs valid=%b inst=%h pc=%h pc4=%h want 0",
                     IF_valid, IF_inst, IF_pc, IF_pc4);
        end
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] exp_pc;
        bit          prev_hold;
        int          caps;
        rst       = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        rand_lat  = 1;
        exp_pc    = RST_PC;
        prev_hold = 0;
        caps      = 0;
        #1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(99, 0) < 30);
            flush = ($urandom_range(99, 0) < 7);
            if ($urandom_range(15, 0) == 0) redirect_pc = 32'hFFFF_FFFC | 32'($urandom_range(3, 0));
            else                            redirect_pc = 32'($urandom_range(1023, 0));
            #1;
            if (IF_valid === 1'b1) begin
                checks++;
                if (IF_pc !== exp_pc || IF_pc4 !== exp_pc + 32'd4 || IF_inst !== (exp_pc ^ KEY)) begin
                    errors++;
                    $display("[TB] FAIL rand_data cyc=%0d pc=%h pc4=%h inst=%h want %h %h %h",
                             i, IF_pc, IF_pc4, IF_inst, exp_pc, exp_pc + 32'd4, exp_pc ^ KEY);
                end
            end else begin
                checks++;
                if ({IF_inst, IF_pc, IF_pc4} !== '0) begin
                    errors++;
                    $display("[TB] FAIL rand_bubble cyc=%0d inst=%h pc=%h pc4=%h want 0", i, IF_inst, IF_pc, IF_pc4);
                end
            end
            if (prev_hold && !flush) begin
                checks++;
                if (IF_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rand_stall_hold cyc=%0d valid=%b want 1", i, IF_valid);
                end
            end
            if (flush) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
                checks++;
                if (imem_req !== 1'b0 || IF_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rand_flush cyc=%0d req=%b valid=%b want 0 0", i, imem_req, IF_valid);
                end
            end else if (IF_valid === 1'b1 && !stall) begin
                exp_pc = exp_pc + 32'd4;
                caps++;
            end
            if (imem_req === 1'b1) begin
                checks++;
                if (imem_addr !== exp_pc || mem_pend !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rand_req cyc=%0d addr=%h outstanding=%b want %h 0",
                             i, imem_addr, mem_pend, exp_pc);
                end
            end
            prev_hold = (IF_valid === 1'b1) && stall && !flush;
            @(negedge clk);
        end
        checks++;
        if (caps < 100) begin
            errors++;
            $display("[TB] FAIL rand_progress captured=%0d want >=100", caps);
        end
        rand_lat = 0;
        stall    = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_flush_hold();
        test_flush_wait();
        test_stall_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
